// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin arbiter for the register-file write port, with a
// one-stage writeback register, same-cycle bypass of the in-flight write and a
// saturating contention counter.
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              we,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] q_rs1,
    input  logic [ADDR_W-1:0] q_rs2,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd1_data,
    output logic [DATA_W-1:0] fwd2_data,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic {
        PREF_A = 1'b0,
        PREF_B = 1'b1
    } pref_t;

    pref_t              pref_reg;
    pref_t              pref_next;
    logic               wb_valid_reg;
    logic [ADDR_W-1:0]  wb_rd_reg;
    logic [DATA_W-1:0]  wb_data_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic               a_live;
    logic               b_live;
    logic               a_null;
    logic               b_null;
    logic               both_live;
    logic               grant_a;
    logic               grant_b;
    logic               wb_valid_next;
    logic [ADDR_W-1:0]  wb_rd_next;
    logic [DATA_W-1:0]  wb_data_next;
    logic [CNT_W-1:0]   cnt_next;

    // Writes to x0 are architecturally discarded, so they bypass arbitration.
    assign a_live    = a_valid && (a_rd != ZERO_REG);
    assign b_live    = b_valid && (b_rd != ZERO_REG);
    assign a_null    = a_valid && (a_rd == ZERO_REG);
    assign b_null    = b_valid && (b_rd == ZERO_REG);
    assign both_live = a_live && b_live;

    always_comb begin
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        pref_next = pref_reg;
        if (both_live) begin
            grant_a = (pref_reg == PREF_A);
            grant_b = (pref_reg == PREF_B);
        end else begin
            grant_a = a_live;
            grant_b = b_live;
        end
        if (grant_a) begin
            pref_next = PREF_B;
        end else if (grant_b) begin
            pref_next = PREF_A;
        end
    end

    assign a_ready = !rst && (a_null || grant_a);
    assign b_ready = !rst && (b_null || grant_b);

    always_comb begin
        wb_valid_next = 1'b0;
        wb_rd_next    = wb_rd_reg;
        wb_data_next  = wb_data_reg;
        if (grant_a) begin
            wb_valid_next = 1'b1;
            wb_rd_next    = a_rd;
            wb_data_next  = a_data;
        end else if (grant_b) begin
            wb_valid_next = 1'b1;
            wb_rd_next    = b_rd;
            wb_data_next  = b_data;
        end
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (both_live && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pref_reg     <= PREF_A;
            wb_valid_reg <= 1'b0;
            wb_rd_reg    <= '0;
            wb_data_reg  <= '0;
            cnt_reg      <= '0;
        end else begin
            pref_reg     <= pref_next;
            wb_valid_reg <= wb_valid_next;
            wb_rd_reg    <= wb_rd_next;
            wb_data_reg  <= wb_data_next;
            cnt_reg      <= cnt_next;
        end
    end

    assign we           = wb_valid_reg;
    assign rd           = wb_rd_reg;
    assign wdata        = wb_data_reg;
    assign conflict_cnt = cnt_reg;

    // Both bypass ports compare against the same in-flight write.
    logic [ADDR_W-1:0] q_rs     [2];
    logic [1:0]        fwd_hit;
    logic [DATA_W-1:0] fwd_data [2];

    assign q_rs[0] = q_rs1;
    assign q_rs[1] = q_rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
            assign fwd_hit[gi]  = wb_valid_reg && (q_rs[gi] == wb_rd_reg) && (q_rs[gi] != ZERO_REG);
            assign fwd_data[gi] = fwd_hit[gi] ? wb_data_reg : '0;
        end
    endgenerate

    assign fwd1_hit  = fwd_hit[0];
    assign fwd2_hit  = fwd_hit[1];
    assign fwd1_data = fwd_data[0];
    assign fwd2_data = fwd_data[1];

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single register-file write port between two writeback requesters: the ALU result path (port A) and the load unit (port B). Arbitrates round-robin with a valid/ready handshake and registers the granted write into a one-stage writeback register that drives the register file. Exposes a two-read-port bypass so decode can observe the in-flight write before it lands. Also maintains a saturating contention counter for performance debug.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register index width
- CNT_W, 16, contention counter width
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- a_valid  input  1  port A write request
- a_rd  input  ADDR_W  port A destination register
- a_data  input  DATA_W  port A write data
- a_ready  output  1  port A request accepted this cycle
- b_valid, b_rd, b_data, b_ready  same as port A, for port B
- we  output  1  register-file write enable
- rd  output  ADDR_W  register-file write index
- wdata  output  DATA_W  register-file write data
- q_rs1, q_rs2  input  ADDR_W  bypass query indices
- fwd1_hit, fwd2_hit  output  1  query matches the in-flight write
- fwd1_data, fwd2_data  output  DATA_W  in-flight write data; 0 when no hit
- conflict_cnt  output  CNT_W  saturating count of contention cycles

## Operation
- A request is "live" when valid=1 and its rd is not 0. A request with rd=0 is "null".
- Null requests get ready=1 in the same cycle, unconditionally. They are consumed without arbitration and never reach the writeback stage.
- Round-robin pointer `pref` (0=A, 1=B), reset to 0.
- Both live: grant the port selected by `pref`, then set `pref` to the other port. The loser holds valid; the bench must keep its rd/data stable until ready.
- One live: grant it, and set `pref` to the other port.
- None live: no grant; `pref` unchanged.
- ready is high only for the granted live port or for a null request. Ready depends combinationally on valid, rd and `pref` only.
- Writeback stage: on a live grant, load wb_valid=1, rd, wdata from the granted port. With no live grant, wb_valid=0 and rd/wdata hold their old values.
- we = wb_valid. The stage never stalls; the register file accepts every cycle.
- Bypass: fwdN_hit = wb_valid && q_rsN == rd && q_rsN != 0. fwdN_data = hit ? wdata : 0. Both are purely combinational.
- conflict_cnt increments on each cycle with both ports live. It saturates at all-ones and clears only on reset.
- Same rd on A and B in one cycle: serialised by arbitration. The later-granted write is the final register content.

## Timing
- Reset (async assert, held): we=0, rd=0, wdata=0, pref=0, conflict_cnt=0, fwd*_hit=0, fwd*_data=0, a_ready=0, b_ready=0. Ready is forced to 0 while rst=1.
- Reset asserted mid-transfer discards the writeback stage. No write is issued after reset release until a new grant occurs.
- Latency: a request accepted at edge N drives we=1 with its rd/wdata during cycle N+1, for exactly one cycle.
- Throughput: one live write per cycle total. Under continuous dual contention each port gets exactly every other grant.
- Bypass data is valid in the same cycle that we is high. The register file reflects the write from cycle N+2 onward.
- First cycle after reset release: if both ports are live, A wins.

## Test plan
- Single A request: rd=5, data=0xDEADBEEF. Expect a_ready=1 that cycle, then we=1, rd=5, wdata=0xDEADBEEF next cycle, then we=0.
- Both live every cycle for 6 cycles, starting after reset: grants alternate A,B,A,B,A,B; conflict_cnt=6; we stays high continuously from the second cycle.
- A null (rd=0) and B live (rd=7) in the same cycle: a_ready=1 and b_ready=1 in that cycle; only rd=7 is written; conflict_cnt is unchanged.
- Bypass: write rd=3, data=0x1234, with q_rs1=3 and q_rs2=4 during the we cycle. Expect fwd1_hit=1, fwd1_data=0x1234, fwd2_hit=0, fwd2_data=0. With q_rs1=0, expect no hit.
- Assert rst asynchronously mid-cycle while wb_valid=1. Expect we, ready, and conflict_cnt to drop to 0 immediately, with no write after release.
- Force contention for 2^CNT_W+3 cycles (CNT_W overridden to 4): conflict_cnt stops at 15 and does not wrap.
